// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and BCD limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade (0..9) counter digit; carry marks the enable that wraps 9 to 0.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

  assign carry = en && (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap stopwatch: prescaler, command FSM, lap freeze register and a
// cascade of BCD digits driving the display value.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow,
  output logic                  tick
);

  localparam int unsigned    PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  state_t              state, state_next;
  logic [PW-1:0]       pre;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] lap_reg;
  logic [DIGITS:0]     en_chain;
  logic                counting;
  logic                inc;

  assign counting    = (state == RUN) || (state == LAP);
  assign inc         = counting && (pre == PRE_LAST) && !clear;
  assign en_chain[0] = inc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .en    (en_chain[i]),
      .q     (count[4*i +: 4]),
      .carry (en_chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) state_next = RUN;
        RUN:   if (stop) state_next = PAUSE;
               else if (lap) state_next = LAP;
        LAP:   if (stop) state_next = PAUSE;
               else if (lap) state_next = RUN;
        PAUSE: if (!lap && start) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Lap capture samples the count from before this edge's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre      <= '0;
      tick     <= 1'b0;
      overflow <= 1'b0;
      lap_reg  <= '0;
    end else begin
      tick <= inc;
      if (clear) begin
        pre      <= '0;
        overflow <= 1'b0;
      end else begin
        if (counting) begin
          pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
        if (en_chain[DIGITS]) begin
          overflow <= 1'b1;
        end
      end
      if ((state == RUN) && lap && !stop && !clear) begin
        lap_reg <= count;
      end
    end
  end

  always_comb begin
    running    = (state == RUN) || (state == LAP);
    lap_active = (state == LAP);
    bcd_out    = (state == LAP) ? lap_reg : count;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with an arithmetic reference model checked every cycle.
module tb_stopwatch_ctrl;

  localparam int TD   = 4;
  localparam int ND   = 4;
  localparam int MAXV = 10000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] bcd_out;
  logic        running, lap_active, overflow, tick;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .DIGITS(ND)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .lap        (lap),
    .bcd_out    (bcd_out),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // Reference model: modes 0=idle 1=run 2=pause 3=lap; count kept as a plain integer.
  int m_mode = 0, m_count = 0, m_phase = 0, m_lapv = 0, old_count = 0;
  bit m_ovf = 0, m_tick = 0, active = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_count = 0; m_phase = 0; m_lapv = 0; m_ovf = 0; m_tick = 0;
    end else begin
      old_count = m_count;
      active    = (m_mode == 1) || (m_mode == 3);
      m_tick    = 0;
      if (active) begin
        m_phase = m_phase + 1;
        if (m_phase == TD) begin
          m_phase = 0;
          m_count = (m_count + 1) % MAXV;
          if (m_count == 0) m_ovf = 1;
          m_tick = 1;
        end
      end
      if (clear) begin
        m_mode = 0; m_count = 0; m_phase = 0; m_ovf = 0; m_tick = 0;
      end else if (stop) begin
        if (active) m_mode = 2;
      end else if (lap) begin
        if (m_mode == 1) begin m_lapv = old_count; m_mode = 3; end
        else if (m_mode == 3) m_mode = 1;
      end else if (start) begin
        if (m_mode == 0 || m_mode == 2) m_mode = 1;
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("bcd_out",    {16'h0, bcd_out}, {16'h0, to_bcd((m_mode == 3) ? m_lapv : m_count)});
    check("running",    {31'h0, running},    {31'h0, (m_mode == 1 || m_mode == 3)});
    check("lap_active", {31'h0, lap_active}, {31'h0, (m_mode == 3)});
    check("overflow",   {31'h0, overflow},   {31'h0, m_ovf});
    check("tick",       {31'h0, tick},       {31'h0, m_tick});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input logic s, input logic p, input logic c, input logic l);
    start = s; stop = p; clear = c; lap = l;
    @(negedge clk);
    start = 0; stop = 0; clear = 0; lap = 0;
  endtask

  int nticks;

  initial begin
    // Reset and idle
    cyc(3);
    reset = 1'b1;
    cyc(20);
    check("idle_bcd", {16'h0, bcd_out}, 32'h0);
    check("idle_run", {31'h0, running}, 32'h0);

    // First increment latency and tick period
    cmd(1, 0, 0, 0);
    cyc(3);
    check("pre_first", {16'h0, bcd_out}, 32'h0000);
    cyc(1);
    check("first_inc", {16'h0, bcd_out}, 32'h0001);
    check("first_tick", {31'h0, tick}, 32'h1);
    cyc(36);
    check("ten", {16'h0, bcd_out}, 32'h0010);
    nticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) nticks++;
    end
    check("tick_count", nticks, 10);

    // Carries and full-scale overflow
    cyc(316);
    check("c99", {16'h0, bcd_out}, 32'h0099);
    cyc(4);
    check("c100", {16'h0, bcd_out}, 32'h0100);
    cyc(39596);
    check("c9999", {16'h0, bcd_out}, 32'h9999);
    check("ovf_before", {31'h0, overflow}, 32'h0);
    cyc(4);
    check("wrap", {16'h0, bcd_out}, 32'h0000);
    check("ovf_set", {31'h0, overflow}, 32'h1);
    cyc(20);
    check("after_wrap", {16'h0, bcd_out}, 32'h0005);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);
    cmd(0, 0, 1, 0);
    check("ovf_clr", {31'h0, overflow}, 32'h0);
    check("clr_bcd", {16'h0, bcd_out}, 32'h0);

    // Lap freeze
    cmd(1, 0, 0, 0);
    cyc(92);
    check("at23", {16'h0, bcd_out}, 32'h0023);
    cmd(0, 0, 0, 1);
    check("lap_hold", {16'h0, bcd_out}, 32'h0023);
    check("lap_act", {31'h0, lap_active}, 32'h1);
    cyc(47);
    check("lap_hold2", {16'h0, bcd_out}, 32'h0023);
    cmd(0, 0, 0, 1);
    check("lap_exit", {16'h0, bcd_out}, 32'h0035);
    check("lap_off", {31'h0, lap_active}, 32'h0);

    // Pause mid-period preserves prescaler phase
    cmd(0, 1, 0, 0);
    check("pause_run", {31'h0, running}, 32'h0);
    cyc(50);
    check("pause_hold", {16'h0, bcd_out}, 32'h0035);
    cmd(1, 0, 0, 0);
    cyc(1);
    check("resume1", {16'h0, bcd_out}, 32'h0035);
    cyc(1);
    check("resume2", {16'h0, bcd_out}, 32'h0036);

    // Simultaneous commands
    cmd(1, 0, 1, 0);
    check("clr_start", {16'h0, bcd_out}, 32'h0);
    check("clr_start_run", {31'h0, running}, 32'h0);
    cmd(1, 0, 0, 0);
    cyc(10);
    cmd(0, 1, 0, 1);
    check("stop_lap_run", {31'h0, running}, 32'h0);
    check("stop_lap_act", {31'h0, lap_active}, 32'h0);
    cmd(0, 0, 0, 1);
    check("pause_lap_ign", {31'h0, lap_active}, 32'h0);
    cmd(1, 0, 0, 0);
    cmd(0, 0, 0, 1);
    cyc(9);
    cmd(0, 1, 0, 0);
    check("lap_stop_act", {31'h0, lap_active}, 32'h0);

    // Asynchronous reset mid-run
    cmd(1, 0, 0, 0);
    cyc(10);
    #2 reset = 1'b0;
    #1;
    check("arst_bcd", {16'h0, bcd_out}, 32'h0);
    check("arst_run", {31'h0, running}, 32'h0);
    check("arst_tick", {31'h0, tick}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller that sequences a cascade of mod-10 (0..9) decade digit counters as a start/stop/lap stopwatch.
- A prescaler turns the system clock into count ticks.
- A small FSM gates the ticks and owns clear, pause and lap-freeze.
- Sits between debounced push-button pulses and the 7-segment display driver.

Parameters:
- TICK_DIV, 10: clock cycles per count tick; legal range is 1 and above.
- DIGITS, 4: number of cascaded BCD digits; digit 0 is least significant.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: start/resume command, sampled each clock edge.
- stop, input, 1: pause command.
- clear, input, 1: return to zero and IDLE.
- lap, input, 1: toggle display freeze.
- bcd_out, output, 4*DIGITS: displayed BCD value; digit i is bits [4i+3:4i].
- running, output, 1: high in RUN or LAP.
- lap_active, output, 1: high in LAP.
- overflow, output, 1: sticky flag set by a full-scale wrap.
- tick, output, 1: one-cycle pulse each time the count increments.

Behaviour:
- Reset is asynchronous and active-low on `reset`. While it is low:
  - state = IDLE, prescaler = 0, all digits = 0, lap register = 0.
  - bcd_out = 0, running = 0, lap_active = 0, overflow = 0, tick = 0.
  - Reset mid-operation clears immediately, with no clock edge needed.
- All outputs are registered.
- Commands are sampled on the rising edge, and the new state is visible after that same edge.
- Command priority when several are high in one cycle: clear > stop > lap > start.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: start goes to RUN. Other commands are ignored.
  - RUN: stop goes to PAUSE. lap captures the count into the lap register and goes to LAP.
  - LAP: lap goes to RUN. stop goes to PAUSE. Counting continues in LAP.
  - PAUSE: start goes to RUN. lap is ignored.
  - Any state: clear goes to IDLE, zeroing the prescaler, the digits and overflow.
- Counting and prescaler:
  - The prescaler advances on an edge only if the state before that edge was RUN or LAP. It holds in PAUSE and is 0 in IDLE.
  - Prescaler range is 0..TICK_DIV-1.
  - At an edge where the prescaler is TICK_DIV-1 and the state was RUN or LAP:
    - the prescaler wraps to 0;
    - the digits increment;
    - tick is 1 for the following cycle.
  - With TICK_DIV=1, tick is high on every cycle spent counting.
- Timing from start: if start is sampled at edge k from IDLE, the first increment occurs at edge k+TICK_DIV.
- A stop sampled on a tick edge still applies that increment.
- Digit cascade:
  - Digit 0 increments on tick.
  - Digit i increments on tick only when all lower digits equal 9.
  - Each digit wraps 9 to 0.
  - Digit values stay in 0..9 at all times.
- Overflow: a tick when all digits are 9 wraps every digit to 0 and sets overflow. Overflow stays set until clear or reset; counting continues.
- Lap behaviour:
  - The lap register captures the registered count as it was before that edge, excluding any increment applied on the same edge.
  - bcd_out shows the lap register in LAP and the live count otherwise.
  - Leaving LAP (via lap or stop) shows the live count from the next cycle.
- running = (state is RUN or LAP). lap_active = (state is LAP).

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11;
  - BCD_MAX = 4'd9.
- One sub-module, bcd_digit: a single decade digit.
  - Inputs: clk, reset, sync clear, enable.
  - Outputs: q[3:0] and carry = enable && q==9.
  - Instantiated DIGITS times, with enable of digit i+1 = carry of digit i.
- The top level holds the FSM, the prescaler, the lap register and the output muxing.

Test Plan:
1. reset low for 3 cycles, then high, idle for 20 cycles -> bcd_out=0x0000, running=0, tick=0, overflow=0 throughout. Drop reset mid-RUN between edges -> outputs zero immediately.
2. TICK_DIV=4, start pulse at edge k -> bcd_out=0x0001 after edge k+4 and 0x0010 after edge k+40. tick high for exactly one cycle every 4 cycles.
3. Run to 0x0099 then one more tick -> 0x0100. Preload via run to 0x9999 then one tick -> 0x0000 with overflow=1. Overflow stays 1 over 5 further ticks and clears to 0 one edge after clear.
4. Lap at count 0x0023 -> bcd_out holds 0x0023 and lap_active=1 while the internal count advances. Lap again after 12 ticks -> bcd_out=0x0035 and lap_active=0.
5. Stop with prescaler mid-period, hold PAUSE 50 cycles, then start -> bcd_out constant during PAUSE and running=0. Total counting cycles per increment across the pause equals TICK_DIV (no tick lost or gained).
6. clear and start high in the same cycle while in RUN -> IDLE with bcd_out=0. Stop and lap high together in RUN -> PAUSE with lap_active=0.
